// File: rtl/count_down_timer.sv
// Single-digit countdown: launches on start, decrements on each synchronized
// Clk1Hz rising edge, drives an active-low 7-segment digit and a done flag.
module count_down_timer #(
    parameter int unsigned START_VALUE = 9
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       Clk1Hz,
    input  logic       start,
    output logic       doneCounting,
    output logic [7:0] seg
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEG_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 8'hC0;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             p_q, p_d;
    logic             tick_c;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             done_q, done_d;

    // Active-low {dp,g,f,e,d,c,b,a}; dp held off.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [CNT_W-1:0] digit);
        logic [SEG_W-1:0] pattern;
        unique case (digit)
            4'd0:    pattern = 8'hC0;
            4'd1:    pattern = 8'hF9;
            4'd2:    pattern = 8'hA4;
            4'd3:    pattern = 8'hB0;
            4'd4:    pattern = 8'h99;
            4'd5:    pattern = 8'h92;
            4'd6:    pattern = 8'h82;
            4'd7:    pattern = 8'hF8;
            4'd8:    pattern = 8'h80;
            4'd9:    pattern = 8'h90;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // Synchronizer, edge detect, FSM and registered-output next values.
    always_comb begin
        s1_d    = Clk1Hz;
        s2_d    = s1_q;
        p_d     = s2_q;
        tick_c  = s2_q & ~p_q;
        state_d = state_q;
        count_d = count_q;
        seg_d   = SEG_BLANK;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COUNT;
                    count_d = CNT_W'(START_VALUE);
                end
            end
            ST_COUNT: begin
                if (tick_c) begin
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        unique case (state_d)
            ST_COUNT: seg_d = seg_decode(count_d);
            ST_DONE:  seg_d = SEG_ZERO;
            default:  seg_d = SEG_BLANK;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            p_q     <= 1'b0;
            state_q <= ST_IDLE;
            count_q <= '0;
            seg_q   <= SEG_BLANK;
            done_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            p_q     <= p_d;
            state_q <= state_d;
            count_q <= count_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    assign seg          = seg_q;
    assign doneCounting = done_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Scoreboard bench for count_down_timer: expected {seg,done} pairs are queued
// as stimulus is applied and popped when the DUT output is sampled.
module tb_count_down_timer;

    typedef struct {
        logic [7:0] seg;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hz = 1'b0;
    logic       start = 1'b0;
    logic       start0 = 1'b0;
    logic       done_counting, done0;
    logic [7:0] seg, seg0;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    count_down_timer #(.START_VALUE(9)) dut (
        .Clk100M(clk), .Reset(rst), .Clk1Hz(hz), .start(start),
        .doneCounting(done_counting), .seg(seg)
    );

    count_down_timer #(.START_VALUE(0)) dut0 (
        .Clk100M(clk), .Reset(rst), .Clk1Hz(hz), .start(start0),
        .doneCounting(done0), .seg(seg0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Remainder of a 1000-cycle Clk1Hz period after its rise plus 3 edges.
    task automatic hz_finish;
        clk_n(497);
        hz = 1'b0;
        clk_n(500);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        clk_n(3);
        sb.push_back('{8'hFF, 1'b0});
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL reset_state: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        rst = 1'b0;
        sb.push_back('{8'hFF, 1'b0});
        clk_n(20);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL reset_hold: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        hz = 1'b1;
        sb.push_back('{8'hFF, 1'b0});
        clk_n(10);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL idle_tick_ignored: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        hz = 1'b0;
        clk_n(10);
    endtask

    task automatic test_full_countdown;
        start = 1'b1;
        sb.push_back('{8'h90, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL launch: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        for (int i = 1; i <= 10; i++) begin
            sb.push_back('{exp_seg(10 - i), 1'b0});
            if (i < 10) sb.push_back('{exp_seg(9 - i), 1'b0});
            else        sb.push_back('{8'hC0, 1'b1});
            hz = 1'b1;
            clk_n(2);
            e = sb.pop_front();
            vectors++;
            if ({seg, done_counting} !== {e.seg, e.done}) begin
                miscompares++;
                $display("FAIL pre_tick_%0d: seg=%h done=%b expected seg=%h done=%b", i, seg, done_counting, e.seg, e.done);
            end
            clk_n(1);
            e = sb.pop_front();
            vectors++;
            if ({seg, done_counting} !== {e.seg, e.done}) begin
                miscompares++;
                $display("FAIL tick_%0d: seg=%h done=%b expected seg=%h done=%b", i, seg, done_counting, e.seg, e.done);
            end
            hz_finish();
        end
    endtask

    task automatic test_done_handshake;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{8'hC0, 1'b1});
            clk_n(1);
            e = sb.pop_front();
            vectors++;
            if ({seg, done_counting} !== {e.seg, e.done}) begin
                miscompares++;
                $display("FAIL done_hold_%0d: seg=%h done=%b expected seg=%h done=%b", i, seg, done_counting, e.seg, e.done);
            end
        end
        start = 1'b0;
        sb.push_back('{8'hFF, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL done_release: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        start = 1'b1;
        sb.push_back('{8'h90, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL relaunch: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
    endtask

    task automatic test_start_ignored;
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) start = 1'b0;
            if (i < 10) sb.push_back('{exp_seg(9 - i), 1'b0});
            else        sb.push_back('{8'hC0, 1'b1});
            hz = 1'b1;
            clk_n(3);
            e = sb.pop_front();
            vectors++;
            if ({seg, done_counting} !== {e.seg, e.done}) begin
                miscompares++;
                $display("FAIL nostart_tick_%0d: seg=%h done=%b expected seg=%h done=%b", i, seg, done_counting, e.seg, e.done);
            end
            if (i == 10) begin
                sb.push_back('{8'hFF, 1'b0});
                clk_n(1);
                e = sb.pop_front();
                vectors++;
                if ({seg, done_counting} !== {e.seg, e.done}) begin
                    miscompares++;
                    $display("FAIL done_one_cycle: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
                end
            end
            hz_finish();
        end
    endtask

    task automatic test_reset_mid_count;
        start = 1'b1;
        sb.push_back('{8'h90, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL launch2: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        for (int i = 1; i <= 5; i++) begin
            sb.push_back('{exp_seg(9 - i), 1'b0});
            hz = 1'b1;
            clk_n(3);
            e = sb.pop_front();
            vectors++;
            if ({seg, done_counting} !== {e.seg, e.done}) begin
                miscompares++;
                $display("FAIL pre_reset_tick_%0d: seg=%h done=%b expected seg=%h done=%b", i, seg, done_counting, e.seg, e.done);
            end
            hz_finish();
        end
        // Reset lands in the cycle where the synchronized tick is high.
        start = 1'b0;
        hz = 1'b1;
        clk_n(2);
        rst = 1'b1;
        sb.push_back('{8'hFF, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL reset_with_tick: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        rst = 1'b0;
        sb.push_back('{8'hFF, 1'b0});
        clk_n(5);
        e = sb.pop_front();
        vectors++;
        if ({seg, done_counting} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL idle_after_reset: seg=%h done=%b expected seg=%h done=%b", seg, done_counting, e.seg, e.done);
        end
        hz_finish();
    endtask

    task automatic test_zero_start;
        start0 = 1'b1;
        sb.push_back('{8'hC0, 1'b0});
        sb.push_back('{8'hC0, 1'b0});
        sb.push_back('{8'hC0, 1'b1});
        sb.push_back('{8'hFF, 1'b0});
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg0, done0} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL zero_launch: seg=%h done=%b expected seg=%h done=%b", seg0, done0, e.seg, e.done);
        end
        hz = 1'b1;
        clk_n(2);
        e = sb.pop_front();
        vectors++;
        if ({seg0, done0} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL zero_pre_tick: seg=%h done=%b expected seg=%h done=%b", seg0, done0, e.seg, e.done);
        end
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg0, done0} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL zero_done: seg=%h done=%b expected seg=%h done=%b", seg0, done0, e.seg, e.done);
        end
        start0 = 1'b0;
        clk_n(1);
        e = sb.pop_front();
        vectors++;
        if ({seg0, done0} !== {e.seg, e.done}) begin
            miscompares++;
            $display("FAIL zero_release: seg=%h done=%b expected seg=%h done=%b", seg0, done0, e.seg, e.done);
        end
        hz_finish();
    endtask

    initial begin
        test_reset();
        test_full_countdown();
        test_done_handshake();
        test_start_ignored();
        test_reset_mid_count();
        test_zero_start();
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_down_timer.md
# count_down_timer

Single-digit seconds countdown used by the preliminary-period controller. It launches on `start` and counts from `START_VALUE` down to 0, decrementing once per rising edge of the slow `Clk1Hz` input. The current digit drives an active-low 7-segment pattern, and `doneCounting` is asserted once the count has expired. All logic runs in the `Clk100M` domain; `Clk1Hz` is treated as an asynchronous data input.

## Interface
- `START_VALUE`, default 9: first digit shown after launch; legal range 0..9.
- `Clk100M`  input  1  system clock; all state updates on its rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `Clk1Hz`  input  1  slow 1 Hz square wave, asynchronous to `Clk100M`; only its rising edges matter.
- `start`  input  1  level launch request; a registered level from the period controller.
- `doneCounting`  output  1  high while in DONE.
- `seg`  output  8  active-low segments `{dp,g,f,e,d,c,b,a}`; `dp` is always off (1).

## Operation
- **Tick generation**
  - Two-flop synchronizer `s1 <= Clk1Hz`, `s2 <= s1`, followed by delay flop `p <= s2`.
  - `tick = s2 & ~p`, a one-cycle pulse per `Clk1Hz` rising edge.
- **Counter**
  - 4-bit `count`, range 0..9.
  - Never decrements below 0 and never wraps.
- **State machine**
  - IDLE: `start==1` → COUNT and load `count = START_VALUE`. A tick in the load cycle is ignored.
  - COUNT: on `tick`, if `count==0` → DONE, else `count <= count-1`. With no tick, hold.
  - COUNT ignores `start`; once launched, the countdown always completes.
  - DONE: `start==0` → IDLE, otherwise stay in DONE. Minimum DONE dwell is one cycle.
  - Re-launch requires `start` to be low for at least one cycle after DONE.
- **Segment decode** (`seg` in hex)
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - IDLE: blank, FF.
  - COUNT: decode of `count`.
  - DONE: digit 0, C0.
- **Output registers**
  - `seg` and `doneCounting` are registered from next-state/next-count. They change on the same edge as the state and count.
- **Reset**, when `Reset=1` at a rising edge; it overrides all other activity, including mid-count:
  - state IDLE, `count=0`;
  - `seg=FF`, `doneCounting=0`;
  - `s1`, `s2` and `p` cleared to 0.

## Timing
- **Tick latency**
  - If `Clk1Hz` is first sampled high at edge k, `s2` is high after edge k+1 and `tick` is high during the following cycle.
  - `count` and `seg` update at edge k+2: 2–3 `Clk100M` cycles from the input edge, depending on metastability resolution.
- **Launch latency:** `start` sampled high at edge n in IDLE gives `seg = decode(START_VALUE)` after edge n.
- **Digit dwell**
  - The first digit lasts until the first tick after launch: between 0 and 1 s.
  - Every later digit, including 0, is shown for exactly one `Clk1Hz` period.
- **Done timing**
  - `doneCounting` rises on the edge that consumes the tick seen while `count==0`.
  - Total runtime is `START_VALUE`+1 ticks after launch (first tick partial).
- **Boundary cases**
  - `START_VALUE=0`: shows 0, then DONE on the first tick.
  - `Clk1Hz` high at reset release: a spurious tick may occur; it is harmless in IDLE.
  - `start` pulse of a single cycle: launches fully.
  - `Reset` and `start` in the same cycle: `Reset` wins.

## Test plan
1. **Reset.** Assert `Reset` for 3 cycles with `start=0` → `seg=FF`, `doneCounting=0`, held indefinitely without `start`.
2. **Full countdown.** `START_VALUE=9`; `start=1` held; drive `Clk1Hz` rising edges 1000 cycles apart.
   - After launch, `seg` steps 90,80,F8,82,92,99,B0,A4,F9,C0.
   - `doneCounting` goes to 1 on the 10th tick, with `seg=C0`.
   - Each step lands within 2–3 cycles of its `Clk1Hz` edge.
3. **Done/re-launch handshake.**
   - In DONE with `start=1`: `doneCounting` stays 1.
   - Drop `start`: next edge gives `doneCounting=0`, `seg=FF`.
   - Raise `start` again: `seg=90` and the countdown restarts.
4. **Start ignored mid-count.** Deassert `start` at count 5 → countdown continues to DONE; `doneCounting` is high for exactly 1 cycle, then IDLE.
5. **Reset mid-operation.** Assert `Reset` at count 4 with a `tick` in the same cycle → next edge gives `seg=FF`, `doneCounting=0`, no decrement.
6. **Zero start value.** `START_VALUE=0`; launch → `seg=C0`; first tick → `doneCounting=1`.
